instr_loader: RTL and testbench



---
 rtl/instr_loader_pkg.sv | 16 +
 rtl/instr_loader_xor_acc.sv | 22 ++
 rtl/instr_loader.sv | 106 ++++++++++
 tb/tb_instr_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Purpose: shared types and sizes for the instruction-ROM loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam int ROM_BYTES_DEFAULT = 1024;
    localparam int ROM_BITS          = ROM_BYTES_DEFAULT * 8;

endpackage

// File: rtl/instr_loader_xor_acc.sv
// Purpose: 8-bit running-XOR accumulator with clear and enable.
// Latency: one cycle from enable to updated acc.
// Backpressure: none; the caller gates en.
module instr_loader_xor_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    // Fold each enabled byte into the running XOR; clear or reset zeroes it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= 8'h00;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Purpose: packs a byte stream little-endian into the flat instruction ROM and reports its size.
// Latency: one cycle from byte accept to instr_rom/rom_size update.
// Backpressure: in_ready is high only in LOAD and not during a start pulse.
// Optional: define INSTR_LOADER_CHECKSUM_EN to treat the in_last byte as an XOR checksum.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ROM_BYTES = ROM_BYTES_DEFAULT,
    parameter int PTR_W     = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic [ROM_BYTES*8-1:0] instr_rom,
    output logic [31:0]            rom_size,
    output logic                   busy,
    output logic                   load_done,
    output logic                   load_error
);

    localparam int               BYTE_W   = $clog2(ROM_BYTES);
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(ROM_BYTES);

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic [BYTE_W+2:0]   wr_bit;
    logic                accept;
    logic                full;
    logic                data_wr;

    assign in_ready = (state == LOAD) && !start;
    assign accept   = in_valid && in_ready;
    assign full     = (ptr == FULL_PTR);
    assign wr_bit   = {ptr[BYTE_W-1:0], 3'b000};

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // The checksum byte itself is never stored or folded into the sum.
    assign data_wr = accept && !in_last && !full;

    instr_loader_xor_acc u_xor_acc (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .en    (data_wr),
        .din   (in_data),
        .acc   (csum)
    );
`else
    assign data_wr = accept && !full;
`endif

    // State register; reset returns to IDLE even mid-load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start restarts from anywhere; accepted bytes end the load on last or overflow.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = LOAD;
        end else if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (in_last) begin
                state_nxt = (csum == in_data) ? DONE : ERROR;
            end else if (full) begin
                state_nxt = ERROR;
            end
`else
            if (full) begin
                state_nxt = ERROR;
            end else if (in_last) begin
                state_nxt = DONE;
            end
`endif
        end
    end

    // ROM image and write pointer; start or reset wipes the whole image.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            instr_rom <= '0;
            ptr       <= '0;
        end else if (data_wr) begin
            instr_rom[wr_bit +: 8] <= in_data;
            ptr                    <= ptr + PTR_W'(1);
        end
    end

    assign rom_size   = {{(32-PTR_W){1'b0}}, ptr};
    assign busy       = (state == LOAD);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);

endmodule

// File: tb/tb_instr_loader.sv
// Purpose: randomized self-checking bench for instr_loader against a byte-level model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: in_ready checked against model state every cycle.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int NB = ROM_BYTES_DEFAULT;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic            in_last;
    logic [NB*8-1:0] instr_rom;
    logic [31:0]     rom_size;
    logic            busy;
    logic            load_done;
    logic            load_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte array, byte count, phase and running checksum.
    logic [7:0] m_mem [NB];
    int         m_cnt;
    int         m_state;
    logic [7:0] m_xor;

    instr_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .instr_rom  (instr_rom),
        .rom_size   (rom_size),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < NB; k++) m_mem[k] = 8'h00;
        m_cnt = 0;
        m_xor = 8'h00;
    endtask

    // Apply one clock's worth of spec rules to the model.
    task automatic m_step(input bit rst, input bit st, input bit vld,
                          input logic [7:0] d, input bit lst);
        bit acc;
        acc = vld && (m_state == M_LOAD) && !st;
        if (rst) begin
            m_clear();
            m_state = M_IDLE;
        end else if (st) begin
            m_clear();
            m_state = M_LOAD;
        end else if (acc) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (lst) begin
                m_state = (m_xor == d) ? M_DONE : M_ERR;
            end else if (m_cnt == NB) begin
                m_state = M_ERR;
            end else begin
                m_mem[m_cnt] = d;
                m_cnt++;
                m_xor = m_xor ^ d;
            end
`else
            if (m_cnt == NB) begin
                m_state = M_ERR;
            end else begin
                m_mem[m_cnt] = d;
                m_cnt++;
                if (lst) m_state = M_DONE;
            end
`endif
        end
    endtask

    // One clock: drive at negedge, check ready, clock, update model, check outputs.
    task automatic cycle(input bit rst, input bit st, input bit vld,
                         input logic [7:0] d, input bit lst);
        @(negedge clk);
        reset    = rst;
        start    = st;
        in_valid = vld;
        in_data  = d;
        in_last  = lst;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (m_state == M_LOAD) && !st});
        @(posedge clk);
        m_step(rst, st, vld, d, lst);
        #1;
        chk("rom_size",   rom_size, m_cnt);
        chk("busy",       {31'd0, busy},       {31'd0, m_state == M_LOAD});
        chk("load_done",  {31'd0, load_done},  {31'd0, m_state == M_DONE});
        chk("load_error", {31'd0, load_error}, {31'd0, m_state == M_ERR});
    endtask

    task automatic check_rom(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < NB; k++) begin
            if (instr_rom[k*8 +: 8] !== m_mem[k]) begin
                bad = k;
                break;
            end
        end
        chk($sformatf("%s[%0d]", tag, bad), {24'd0, instr_rom[bad*8 +: 8]}, {24'd0, m_mem[bad]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic send(input logic [7:0] d, input bit lst);
        cycle(1'b0, 1'b0, 1'b1, d, lst);
    endtask

    // Random program of len stored bytes with random gaps; last byte is data or checksum.
    task automatic load_prog(input int len, input bit good_csum);
        logic [7:0] d;
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b1);
            d = 8'($urandom);
`ifdef INSTR_LOADER_CHECKSUM_EN
            send(d, 1'b0);
`else
            send(d, i == len - 1);
`endif
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(good_csum ? m_xor : (m_xor ^ 8'($urandom_range(1, 255))), 1'b1);
`else
        if (good_csum) begin end
`endif
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        m_clear();
        m_state = M_IDLE;
        @(posedge clk);

        // Reset held two cycles.
        cycle(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        check_rom("rst_rom");
        idle(3);

        // Nominal 4-byte load.
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h13, 1'b0);
        send(8'h05, 1'b0);
        send(8'h10, 1'b0);
        send(8'h00, 1'b1);
`ifndef INSTR_LOADER_CHECKSUM_EN
        chk("nom_word", instr_rom[31:0], 32'h00100513);
        chk("nom_size", rom_size, 32'd4);
        chk("nom_done", {31'd0, load_done}, 32'd1);
`endif
        check_rom("nom_rom");
        idle(4);

        // Gapped stream of 8 bytes, valid toggling.
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), i == 7);
            cycle(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0);
        end
`ifndef INSTR_LOADER_CHECKSUM_EN
        chk("gap_size", rom_size, 32'd8);
`endif
        check_rom("gap_rom");

        // Randomized programs.
        for (int it = 0; it < 12; it++) begin
            load_prog($urandom_range(1, 40), 1'($urandom_range(0, 1)));
            check_rom("rnd_rom");
            idle($urandom_range(1, 4));
        end

        // Overflow: fill completely, then one more byte.
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < NB; i++) send(8'($urandom), 1'b0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        send(8'hEE, 1'b0);
        chk("ovf_size", rom_size, NB);
        chk("ovf_err", {31'd0, load_error}, 32'd1);
        check_rom("ovf_rom");
        idle(3);

        // Exact fill with the last flag on the final byte.
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        for (int i = 0; i < NB; i++) send(8'($urandom), 1'b0);
        send(m_xor, 1'b1);
        chk("fullck_done", {31'd0, load_done}, 32'd1);
`else
        for (int i = 0; i < NB; i++) send(8'($urandom), i == NB - 1);
        chk("exact_done", {31'd0, load_done}, 32'd1);
`endif
        chk("exact_size", rom_size, NB);
        check_rom("exact_rom");

        // Restart mid-load with a simultaneous byte.
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
        chk("restart_size", rom_size, 32'd0);
        check_rom("restart_rom");

        // Reset mid-load.
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'h88, 1'b0);
        chk("rstmid_size", rom_size, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        check_rom("rstmid_rom");
        cycle(1'b0, 1'b0, 1'b1, 8'h99, 1'b1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Directed checksum cases.
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h13, 1'b0);
        send(8'h05, 1'b0);
        send(8'h16, 1'b1);
        chk("ck_good_done", {31'd0, load_done}, 32'd1);
        chk("ck_good_size", rom_size, 32'd2);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h13, 1'b0);
        send(8'h05, 1'b0);
        send(8'h17, 1'b1);
        chk("ck_bad_err", {31'd0, load_error}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h00, 1'b1);
        chk("ck_zero_done", {31'd0, load_done}, 32'd1);
        chk("ck_zero_size", rom_size, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h5A, 1'b1);
        chk("ck_one_err", {31'd0, load_error}, 32'd1);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
